// File: rtl/planta_tanque.sv
// Tank plant model: level, mixer timer, quality sample, alarm latch.
// Optional leak enabled with `define PLANTA_VAZAMENTO_EN.
module planta_tanque #(
  parameter int LVL_W      = 8,
  parameter int FULL_LVL   = 200,
  parameter int LOW_LVL    = 20,
  parameter int FILL_RATE  = 4,
  parameter int DRAIN_RATE = 5,
  parameter int MIX_CYCLES = 16,
  parameter int MIX_W      = 8
`ifdef PLANTA_VAZAMENTO_EN
  ,
  parameter int LEAK_PERIOD = 8
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             MOTOR,
  input  logic             EV,
  input  logic             VE,
  input  logic             ALARME,
  input  logic             quality_in,
  input  logic             ack_alarm,
  output logic             PG,
  output logic             EB,
  output logic             CQ,
  output logic             CH,
  output logic             RO,
  output logic [LVL_W-1:0] level,
  output logic             alarm_latched
);

  localparam int SW = LVL_W + 2;

  localparam logic [LVL_W-1:0] FULL_V =
    LVL_W'(FULL_LVL);
  localparam logic [LVL_W-1:0] LOW_V =
    LVL_W'(LOW_LVL);
  localparam logic signed [SW-1:0] LVL_MAX =
    SW'((1 << LVL_W) - 1);
  localparam logic signed [SW-1:0] FILL_S =
    SW'(FILL_RATE);
  localparam logic signed [SW-1:0] DRAIN_S =
    SW'(DRAIN_RATE);
  localparam logic [MIX_W-1:0] MIX_LAST =
    MIX_W'(MIX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MIXING,
    S_DONE
  } mix_st_e;

  mix_st_e          state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [MIX_W-1:0] mix_cnt_q, mix_cnt_d;
  logic             ch_q, ch_d;
  logic             ro_q, ro_d;
  logic             alarm_q, alarm_d;

  logic             ev_eff;
  logic             leak;
  logic signed [SW-1:0] fill_s;
  logic signed [SW-1:0] drain_s;
  logic signed [SW-1:0] leak_s;
  logic signed [SW-1:0] sum;

  // inlet is blocked while an alarm is pending
  assign ev_eff = EV & ~alarm_q;

`ifdef PLANTA_VAZAMENTO_EN
  localparam int LW = $clog2(LEAK_PERIOD + 1);
  localparam logic [LW-1:0] LEAK_LAST =
    LW'(LEAK_PERIOD - 1);

  logic [LW-1:0] leak_cnt_q, leak_cnt_d;

  // free-running leak period counter
  always_comb begin
    leak       = (leak_cnt_q == LEAK_LAST);
    leak_cnt_d = leak ? '0 : leak_cnt_q + LW'(1);
  end

  // leak counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) leak_cnt_q <= '0;
    else          leak_cnt_q <= leak_cnt_d;
  end
`else
  assign leak = 1'b0;
`endif

  // signed level sum, saturated to the counter range
  always_comb begin
    fill_s  = ev_eff ? FILL_S : '0;
    drain_s = VE ? DRAIN_S : '0;
    leak_s  = leak ? SW'(1) : '0;
    sum     = $signed({2'b00, level_q})
            + fill_s - drain_s - leak_s;
    level_d = sum[LVL_W-1:0];
    if (sum < 0)
      level_d = '0;
    else if (sum > LVL_MAX)
      level_d = '1;
  end

  // mixer FSM next state, quality sample, alarm latch
  always_comb begin
    state_d   = state_q;
    mix_cnt_d = mix_cnt_q;
    ro_d      = 1'b0;
    ch_d      = 1'b0;
    alarm_d   = alarm_q;
    if (level_q == '0) begin
      state_d   = S_IDLE;
      mix_cnt_d = '0;
    end else if (state_q != S_IDLE && ev_eff) begin
      state_d   = S_IDLE;
      mix_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          mix_cnt_d = '0;
          if (MOTOR) begin
            state_d   = S_MIXING;
            mix_cnt_d = MIX_W'(1);
          end
        end
        S_MIXING: begin
          if (MOTOR) begin
            if (mix_cnt_q == MIX_LAST)
              state_d = S_DONE;
            else
              mix_cnt_d = mix_cnt_q + MIX_W'(1);
          end
        end
        S_DONE: begin
          if (VE) begin
            state_d   = S_IDLE;
            mix_cnt_d = '0;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mix_cnt_d = '0;
        end
      endcase
    end
    if (state_d == S_DONE) begin
      ch_d = 1'b1;
      ro_d = (state_q == S_DONE) ? ro_q
                                 : quality_in;
    end
    if (ALARME)
      alarm_d = 1'b1;
    else if (ack_alarm)
      alarm_d = 1'b0;
  end

  // plant state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      level_q   <= '0;
      mix_cnt_q <= '0;
      ch_q      <= 1'b0;
      ro_q      <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      mix_cnt_q <= mix_cnt_d;
      ch_q      <= ch_d;
      ro_q      <= ro_d;
      alarm_q   <= alarm_d;
    end
  end

  assign level         = level_q;
  assign PG            = (level_q >= FULL_V);
  assign EB            = (level_q == '0);
  assign CQ            = (level_q <= LOW_V);
  assign CH            = ch_q;
  assign RO            = ro_q;
  assign alarm_latched = alarm_q;

endmodule

// File: tb/tb_planta_tanque.sv
// Bench for planta_tanque: directed plan plus random
// stimulus, checked by a queue-based scoreboard.
module tb_planta_tanque;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       MOTOR = 0, EV = 0, VE = 0;
  logic       ALARME = 0, quality_in = 0, ack_alarm = 0;
  logic       PG, EB, CQ, CH, RO, alarm_latched;
  logic [7:0] level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int lvl;
    bit pg, eb, cq, ch, ro, al;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int m_lvl;
  bit m_active;
  int m_mc;
  bit m_ro;
  bit m_al;
  int m_lk;

  planta_tanque dut (
    .clock(clock), .reset_n(reset_n),
    .MOTOR(MOTOR), .EV(EV), .VE(VE),
    .ALARME(ALARME), .quality_in(quality_in),
    .ack_alarm(ack_alarm),
    .PG(PG), .EB(EB), .CQ(CQ), .CH(CH), .RO(RO),
    .level(level), .alarm_latched(alarm_latched)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_lvl = 0; m_active = 0; m_mc = 0;
    m_ro = 0; m_al = 0; m_lk = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.lvl = m_lvl;
    e.pg  = (m_lvl >= 200);
    e.eb  = (m_lvl == 0);
    e.cq  = (m_lvl <= 20);
    e.ch  = m_active && (m_mc >= 16);
    e.ro  = m_ro;
    e.al  = m_al;
    return e;
  endfunction

  function automatic void model_step(
    bit ev, bit ve, bit mo, bit al, bit ak, bit q);
    bit inflow;
    bit was_done;
    bit now_done;
    int nl;
    int leak;
    inflow   = ev && !m_al;
    was_done = m_active && (m_mc >= 16);
    leak = 0;
`ifdef PLANTA_VAZAMENTO_EN
    if (m_lk == 7) leak = 1;
    m_lk = (m_lk + 1) % 8;
`endif
    nl = m_lvl + (inflow ? 4 : 0)
       - (ve ? 5 : 0) - leak;
    if (nl < 0) nl = 0;
    if (nl > 255) nl = 255;
    if (m_lvl == 0 || (m_active && inflow) ||
        (was_done && ve)) begin
      m_active = 0;
      m_mc = 0;
    end else if (!m_active) begin
      if (mo) begin
        m_active = 1;
        m_mc = 1;
      end
    end else if (!was_done && mo) begin
      m_mc = m_mc + 1;
    end
    now_done = m_active && (m_mc >= 16);
    if (!now_done)     m_ro = 0;
    else if (!was_done) m_ro = q;
    if (al)      m_al = 1;
    else if (ak) m_al = 0;
    m_lvl = nl;
  endfunction

  // entered and left at a falling edge
  task automatic step(bit ev, bit ve, bit mo,
                      bit al, bit ak, bit q);
    EV = ev; VE = ve; MOTOR = mo;
    ALARME = al; ack_alarm = ak; quality_in = q;
    model_step(ev, ve, mo, al, ak, q);
    exp_q.push_back(model_out());
    @(negedge clock);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    EV = 0; VE = 0; MOTOR = 0;
    ALARME = 0; ack_alarm = 0; quality_in = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic cmp(string name, exp_t e);
    total++;
    if (level !== 8'(e.lvl) || PG !== e.pg ||
        EB !== e.eb || CQ !== e.cq ||
        CH !== e.ch || RO !== e.ro ||
        alarm_latched !== e.al) begin
      bad++;
      $display("FAIL %s t=%0t got lvl=%0d pg=%b eb=%b cq=%b ch=%b ro=%b al=%b want lvl=%0d pg=%b eb=%b cq=%b ch=%b ro=%b al=%b",
        name, $time, level, PG, EB, CQ, CH, RO,
        alarm_latched, e.lvl, e.pg, e.eb, e.cq,
        e.ch, e.ro, e.al);
    end
  endtask

  // monitor: one registered result per rising edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0)
        cmp("cycle", exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    @(negedge clock);
    cmp("reset", model_out());
    do_reset();

    // fill to 200 and beyond into saturation
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);

    // drain down to 3, then one more drain to 0
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(2);

    // mixing with pause, quality sample, drain exit
    do_reset();
    for (int i = 0; i < 25; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0);
    idle(5);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    idle(3);
    step(0, 1, 0, 0, 0, 0);
    idle(2);

    // abort after 9 mixing cycles by fresh inflow
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
    idle(2);

    // alarm latch and inlet blocking
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);

    // asynchronous reset with level 120 and CH set
    do_reset();
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    cmp("async_reset", model_out());
    @(negedge clock);
    reset_n = 1'b1;

    // leak drain from 16 over 64 idle cycles
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    idle(64);

    // random closed-loop traffic
    for (int i = 0; i < 3000; i++) begin
      bit ev, ve, mo, al, ak, q;
      ev = ($urandom_range(99) < 35);
      ve = ($urandom_range(99) < 25);
      mo = ($urandom_range(99) < 70);
      al = ($urandom_range(99) < 3);
      ak = ($urandom_range(99) < 10);
      q  = $urandom_range(1);
      if ($urandom_range(999) == 0) begin
        do_reset();
      end
      step(ev, ve, mo, al, ak, q);
    end

    idle(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/planta_tanque.md
Name: planta_tanque

Overview:
- Behavioural plant model at the far end of the main control FSM's actuator/sensor interface.
- Consumes the FSM actuator outputs MOTOR, EV, VE and ALARME, and produces the sensor inputs PG, CH, RO, CQ and EB.
- Used as the closed-loop environment for the control FSM, in simulation and on board.
- Models tank level, mixing time, quality sampling and an alarm latch with registered state.

Parameters:
- LVL_W, 8, width of the tank level counter.
- FULL_LVL, 200, level at or above which PG asserts.
- LOW_LVL, 20, level at or below which CQ asserts.
- FILL_RATE, 4, level increment per cycle while EV=1.
- DRAIN_RATE, 5, level decrement per cycle while VE=1.
- MIX_CYCLES, 16, cycles of MOTOR=1 required for CH to assert.
- MIX_W, 8, width of the mix counter; must satisfy 2^MIX_W > MIX_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- MOTOR  in  1  mixer motor command.
- EV  in  1  inlet valve command.
- VE  in  1  outlet valve command.
- ALARME  in  1  alarm command.
- quality_in  in  1  external product-quality stimulus.
- ack_alarm  in  1  clears the alarm latch.
- PG  out  1  tank full: level >= FULL_LVL.
- EB  out  1  tank empty: level == 0.
- CQ  out  1  low level: level <= LOW_LVL.
- CH  out  1  mixing complete.
- RO  out  1  sampled quality result.
- level  out  LVL_W  current tank level.
- alarm_latched  out  1  alarm has been seen and not acknowledged.

Behaviour:
- Reset (reset_n=0, asynchronous): level=0, mix_cnt=0, CH=0, RO=0, alarm_latched=0. Derived sensors at reset: EB=1, CQ=1, PG=0.
- All state updates on the rising edge of clock. PG, EB and CQ are combinational compares of the registered level, so they reflect a level change in the cycle after the actuator input was sampled (1-cycle latency).
- Level update per cycle:
  - delta = (EV ? FILL_RATE : 0) - (VE ? DRAIN_RATE : 0), computed in LVL_W+2 signed bits.
  - level_next = level + delta, saturating to [0, 2^LVL_W-1]. No wrap-around in either direction.
  - EV and VE both high: both terms apply; the net delta is used.
- Mix counter, a 3-state FSM IDLE / MIXING / DONE:
  - IDLE: mix_cnt=0, CH=0. Goes to MIXING when MOTOR=1 and level != 0.
  - MIXING: mix_cnt increments each cycle MOTOR=1 and holds when MOTOR=0. Reaching MIX_CYCLES-1 with MOTOR=1 moves to DONE; CH=1 from the next cycle.
  - DONE: CH=1. Returns to IDLE, clearing CH and mix_cnt, when VE=1 or level becomes 0.
  - EV=1 during MIXING or DONE (fresh inflow) returns to IDLE: mix_cnt=0, CH=0.
  - level==0 forces IDLE from any state.
- RO: sampled from quality_in on the cycle the FSM enters DONE; held until the FSM leaves DONE, then cleared to 0.
- Alarm latch:
  - alarm_latched sets when ALARME=1 and clears when ack_alarm=1.
  - Both high in the same cycle: set wins.
  - While alarm_latched=1, EV is ignored (the inlet is blocked). VE and MOTOR still act.
- Reset mid-operation: all state returns to reset values immediately. No partial level is retained.

Optional Feature:
- Macro: PLANTA_VAZAMENTO_EN.
- Defined: adds parameter LEAK_PERIOD (default 8) and a free-running leak counter.
  - Every LEAK_PERIOD-th cycle, 1 is subtracted from level, combined in the same signed sum and saturated at 0.
  - The leak counter resets to 0 on reset_n=0.
- Undefined: no leak. Level changes only through EV and VE.

Test Plan:
- Fill: reset, EV=1 for 50 cycles.
  - level=200 after cycle 50.
  - PG=1 from the following cycle.
  - EB drops one cycle after the first EV=1.
  - CQ=0 once level reaches 24.
- Saturation: LVL_W=8, EV=1 for 70 cycles -> level saturates at 255 with no wrap. Then VE=1 alone from level=3 -> level=0 next cycle, EB=1.
- Mixing: level=100, MOTOR=1 for 10 cycles, 0 for 5, then 1 for 6 -> CH=1 exactly after the 16th MOTOR-high cycle. With quality_in=1 at DONE entry, RO=1; then VE=1 -> CH=0 and RO=0 next cycle.
- Mix abort: in MIXING with mix_cnt=9, pulse EV=1 -> mix_cnt=0, CH stays 0, FSM=IDLE.
- Alarm:
  - ALARME=1 one cycle -> alarm_latched=1.
  - EV=1 for 10 cycles -> level unchanged.
  - ack_alarm=1 together with ALARME=1 -> latch stays 1.
  - ack_alarm alone -> latch 0; EV then fills at 4/cycle.
- Async reset: assert reset_n=0 mid-cycle with level=120 and CH=1 -> level=0, CH=0, EB=1 without waiting for a clock edge. With PLANTA_VAZAMENTO_EN: level=16, idle actuators, 64 cycles -> level=8.
